imem_loader: RTL and testbench

- Boot-time sequencer for instruction memory.
- Receives a byte stream (e.g. from UART RX), parses a 4-byte word-count header and assembles little-endian 32-bit instruction words.
- Issues one write per word to the instruction memory write port (we/addr/dout style) and holds the CPU core in reset until the program image is fully written.
- Sits between the UART receiver, the instruction memory write port and the core reset input.

---
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: parses a little-endian word-count header from a byte stream, writes words to imem, holds the core in reset.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
  // rx_ready is registered and depends only on the loader state.
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_DATA  = 3'd1,
    S_FLUSH = 3'd2,
    S_DONE  = 3'd3
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM = 3'd4
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER = S_CSUM;
`else
  localparam state_t S_AFTER = S_FLUSH;
`endif

  state_t      state, state_next;
  logic [1:0]  byte_idx;
  logic [23:0] asm_word;
  logic [31:0] n_words;
  logic [31:0] word_cnt;
  logic        accept, grp_full, last_word, do_write, set_err, ready_next;
  logic [31:0] assembled;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept    = rx_valid && rx_ready;
  assign grp_full  = accept && (byte_idx == 2'd3);
  assign assembled = {rx_data, asm_word};
  assign last_word = (word_cnt == n_words - 32'd1);
  assign do_write  = (state == S_DATA) && grp_full;
  assign cpu_rst   = !(done && !err);

  always_comb begin
    state_next = state;
    set_err    = 1'b0;
    case (state)
      S_HDR: begin
        if (grp_full) begin
          if (assembled > DEPTH_LIM) begin
            set_err    = 1'b1;
            state_next = S_FLUSH;
          end else if (assembled == 32'd0) begin
            state_next = S_AFTER;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA:  if (grp_full && last_word) state_next = S_AFTER;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_next = S_FLUSH;
          set_err    = (rx_data != csum);
        end
      end
`endif
      S_FLUSH: state_next = S_DONE;
      S_DONE:  if (reload) state_next = S_HDR;
      default: state_next = S_HDR;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign ready_next = (state_next == S_HDR) || (state_next == S_DATA) || (state_next == S_CSUM);
`else
  assign ready_next = (state_next == S_HDR) || (state_next == S_DATA);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HDR;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'd0;
      done       <= 1'b0;
      err        <= 1'b0;
      byte_idx   <= 2'd0;
      asm_word   <= 24'd0;
      n_words    <= 32'd0;
      word_cnt   <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      rx_ready <= ready_next;
      imem_we  <= do_write;
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    asm_word[7:0]   <= rx_data;
          2'd1:    asm_word[15:8]  <= rx_data;
          2'd2:    asm_word[23:16] <= rx_data;
          default: ;
        endcase
      end
      if (state == S_HDR && grp_full) n_words <= assembled;
      if (do_write) begin
        imem_wdata <= assembled;
        imem_addr  <= BASE_ADDR + (word_cnt << 2);
        word_cnt   <= word_cnt + 32'd1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == S_DATA && accept) csum <= csum ^ rx_data;
`endif
      if (set_err) err <= 1'b1;
      if (state == S_FLUSH) done <= 1'b1;
      // Reload wipes the previous image's bookkeeping so the next header starts clean.
      if (state == S_DONE && reload) begin
        done     <= 1'b0;
        err      <= 1'b0;
        byte_idx <= 2'd0;
        asm_word <= 24'd0;
        n_words  <= 32'd0;
        word_cnt <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= 8'd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle vector table for the nominal load plus directed multi-cycle sequences.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        reload = 1'b0;
  logic        rx_ready, imem_we, cpu_rst, done, err;
  logic [31:0] imem_addr, imem_wdata;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img[0:7];

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rl;
    logic        ready, we, done, err, crst;
    logic [31:0] addr, data;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic ready, logic we,
                              logic [31:0] addr, logic [31:0] data,
                              logic dn, logic er, logic crst);
    vec_t r;
    r.v = v; r.d = d; r.rl = 1'b0;
    r.ready = ready; r.we = we; r.addr = addr; r.data = data;
    r.done = dn; r.err = er; r.crst = crst;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write scoreboard: every imem_we pulse must match the head of exp_q.
  always @(posedge clk) begin
    #1;
    if (imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h", imem_addr, imem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL write: got %0h expected %0h", {imem_addr, imem_wdata}, e);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: rx_ready 0 required 1");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_timeout", done, 1);
  endtask

  task automatic load_image(input int n, input int gap, input logic bad_csum);
    logic [7:0]  cs;
    logic [31:0] hdr;
    cs  = 8'h00;
    hdr = n;
    if (n <= 4)
      for (int i = 0; i < n; i++) exp_q.push_back({32'(4 * i), img[i]});
    for (int k = 0; k < 4; k++) begin
      idle(gap);
      send_byte(hdr[8*k +: 8]);
    end
    if (n <= 4) begin
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) begin
          cs = cs ^ img[i][8*k +: 8];
          idle(gap);
          send_byte(img[i][8*k +: 8]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
      idle(gap);
      send_byte(bad_csum ? 8'h00 : cs);
`endif
    end
    if (bad_csum) cs = 8'h00;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    @(posedge clk);
    #1;
    reload   = 1'b0;
    rx_valid = 1'b0;
    chk("reload_ctl", {cpu_rst, done, err, rx_ready}, 4'b1001);
  endtask

  initial begin
    img[0] = 32'h3e800093;
    img[1] = 32'h83000113;

    // Reset values while rst is held.
    #2;
    chk("reset_vals", {rx_ready, imem_we, cpu_rst, done, err}, 5'b00100);
    chk("reset_addr_data", {imem_addr, imem_wdata}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", rx_ready, 1);

    // Nominal load, cycle by cycle.
    exp_q.push_back({32'h0, 32'h3e800093});
    exp_q.push_back({32'h4, 32'h83000113});
    vecs.push_back(mk(1, 8'h02, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h93, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h80, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h3e, 1, 1, 32'h0, 32'h3e800093, 0, 0, 1));
    vecs.push_back(mk(1, 8'h13, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h01, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0, 0, 1));
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs.push_back(mk(1, 8'h83, 1, 1, 32'h4, 32'h83000113, 0, 0, 1));
    vecs.push_back(mk(1, 8'hbc, 0, 0, 0, 0, 0, 0, 1));
`else
    vecs.push_back(mk(1, 8'h83, 0, 1, 32'h4, 32'h83000113, 0, 0, 1));
`endif
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 8'hff, 0, 0, 0, 0, 1, 0, 0));
    foreach (vecs[i]) begin
      @(negedge clk);
      rx_valid = vecs[i].v;
      rx_data  = vecs[i].d;
      reload   = vecs[i].rl;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ctl", i), {rx_ready, imem_we, done, err, cpu_rst},
          {vecs[i].ready, vecs[i].we, vecs[i].done, vecs[i].err, vecs[i].crst});
      if (vecs[i].we)
        chk($sformatf("vec%0d_write", i), {imem_addr, imem_wdata}, {vecs[i].addr, vecs[i].data});
    end
    rx_valid = 1'b0;
    chk("nominal_q_empty", exp_q.size(), 0);

    // Reload with a simultaneous byte, then an empty image.
    do_reload();
    for (int k = 0; k < 4; k++) send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    chk("empty_flush", {done, rx_ready, imem_we}, 3'b000);
    @(posedge clk);
    #1;
    chk("empty_done", {done, err, cpu_rst}, 3'b100);

    // Gappy stream: same image, random rx_data while rx_valid is low.
    do_reload();
    load_image(2, 3, 1'b0);
    wait_done(100);
    chk("gappy_status", {err, cpu_rst}, 2'b00);
    chk("gappy_q_empty", exp_q.size(), 0);

    // Oversize header rejected; no further bytes accepted.
    do_reload();
    load_image(5, 0, 1'b0);
    wait_done(20);
    chk("oversize_status", {err, cpu_rst, rx_ready}, 3'b110);
    repeat (3) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      chk("oversize_no_ready", rx_ready, 0);
    end
    rx_valid = 1'b0;

    // Exactly DEPTH_WORDS words is accepted.
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    do_reload();
    load_image(4, 0, 1'b0);
    wait_done(50);
    chk("full_depth_status", {err, cpu_rst}, 2'b00);
    chk("full_depth_q_empty", exp_q.size(), 0);

    // Reset in the middle of word 1.
    img[0] = 32'h3e800093;
    img[1] = 32'h83000113;
    do_reload();
    exp_q.push_back({32'h0, 32'h3e800093});
    send_byte(8'h02);
    for (int k = 0; k < 3; k++) send_byte(8'h00);
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8]);
    send_byte(8'h13);
    send_byte(8'h01);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_vals", {rx_ready, imem_we, cpu_rst, done, err}, 5'b00100);
    chk("midrst_addr_data", {imem_addr, imem_wdata}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    load_image(2, 0, 1'b0);
    wait_done(50);
    chk("after_rst_status", {err, cpu_rst}, 2'b00);
    chk("after_rst_q_empty", exp_q.size(), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reload();
    load_image(2, 0, 1'b1);
    wait_done(50);
    chk("bad_csum_status", {err, cpu_rst}, 2'b11);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
